imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate generator in the decode stage.
- Decodes I/S/B/U/J immediates and adds shift-amount and CSR-zimm immediates.
- Sign- or zero-extends every immediate to XLEN.
- Registers the result behind a valid/ready skid buffer, so decode can be backpressured by issue without dropping instructions.
- Carries a sideband tag (normally the PC) alongside each result.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64.
- TAG_W, 32, width of the sideband tag passed through unmodified.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high
- i_valid  in  1  upstream has an instruction
- o_ready  out  1  block can accept an instruction; registered
- i_inst  in  32  raw instruction word
- i_fmt  in  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 ZIMM
- i_tag  in  TAG_W  sideband tag
- i_flush  in  1  discard all held entries
- o_valid  out  1  result available
- i_ready  in  1  downstream accepts the result
- o_imm  out  XLEN  decoded immediate
- o_tag  out  TAG_W  tag matching o_imm
- o_illegal  out  1  immediate encoding is illegal for this XLEN
- o_stall_cnt  out  32  present only with IMM_STATS_EN

Behaviour:
- Clocking/reset:
  - Single clock domain, i_clk.
  - i_rst is synchronous, active-high.
  - On a reset cycle, inputs are ignored.
  - After reset: o_valid=0, o_ready=1, o_imm=0, o_tag=0, o_illegal=0, o_stall_cnt=0.
- Handshakes:
  - Accept occurs when i_valid && o_ready.
  - Output transfer occurs when o_valid && i_ready.
- Latency: result appears on o_imm exactly 1 cycle after accept when the output register is empty.
- Payload format: decode is combinational on the input side. The registered payload is {imm, tag, illegal}.
- Immediate rules, with s = i_inst[31]:
  - NONE: 0.
  - I: sext(inst[31:20]).
  - S: sext({inst[31:25], inst[11:7]}).
  - B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - U: sext({inst[31:12], 12'b0}). For XLEN=64, bits 63:32 = s.
  - J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - SHAMT: zero-extended. XLEN=32 uses inst[24:20]; XLEN=64 uses inst[25:20].
  - ZIMM: zext(inst[19:15]).
- Illegal flag: o_illegal=1 only for SHAMT with XLEN=32 and inst[25]=1. o_imm still carries zext(inst[24:20]).
- Skid buffer states:
  - EMPTY: output register invalid.
  - ONE: output register valid, skid register empty.
  - TWO: both registers valid.
- State transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept + no transfer -> TWO; the new entry goes to skid.
  - ONE + accept + transfer -> ONE; output register reloads from the input.
  - ONE + transfer + no accept -> EMPTY.
  - TWO + transfer -> ONE; skid moves to the output register.
  - o_ready = (state != TWO), registered, so accept is impossible in TWO.
- Ordering: strict FIFO; no entry is lost or duplicated.
- Output stability: o_imm, o_tag and o_illegal stay stable while o_valid && !i_ready.
- Flush:
  - i_flush=1 -> next cycle state=EMPTY, o_valid=0, o_ready=1.
  - An input presented in the flush cycle is dropped.
  - An output transfer in the same cycle still counts as completed downstream.
  - Flush during reset is a no-op; reset dominates.
- Simultaneous accept and transfer in ONE: sustains 1 instruction/cycle throughput.

Optional Feature:
- Macro: IMM_STATS_EN.
- Defined:
  - o_stall_cnt exists.
  - Increments by 1 each cycle with o_valid && !i_ready.
  - Saturates at 0xFFFFFFFF.
  - Cleared by i_rst only; i_flush does not clear it.
- Undefined:
  - Port and counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- XLEN=32, fmt=I, inst=0xFFF00093, i_ready=1 -> next cycle o_valid=1, o_imm=0xFFFFFFFF, o_tag equals the input tag.
- XLEN=32, fmt=B, inst=0xFE000EE3 -> o_imm=0xFFFFFFFC. With fmt=J, inst=0x0080006F -> o_imm=0x00000008.
- XLEN=64, fmt=U, inst=0x800002B7 -> o_imm=0xFFFFFFFF80000000. With fmt=SHAMT, inst=0x03F01013 -> o_imm=63, o_illegal=0.
- XLEN=32, fmt=SHAMT, inst=0x02301013 (inst[25]=1) -> o_illegal=1, o_imm=3.
- Backpressure: i_ready=0, three back-to-back valid instructions tagged 1, 2, 3:
  - Tags 1 and 2 are accepted.
  - o_ready=0 after the second accept.
  - Tag 3 is held.
  - After releasing i_ready, o_tag sequence is 1, 2, 3 with no gaps or duplicates.
  - With IMM_STATS_EN, o_stall_cnt equals the number of stalled cycles.
- Flush in state TWO -> next cycle o_valid=0, o_ready=1. Then a new accept gives o_valid=1 one cycle later with the new tag. Repeat with reset asserted mid-stream -> all outputs return to reset values.

Source files
------------

// File: rtl/imm_gen_pipe_if.sv
// Bus bundle for imm_gen_pipe: upstream instruction handshake, downstream
// result handshake, flush, and (with IMM_STATS_EN) the stall counter.
// slave = the immediate generator, master = whoever drives it.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic              i_valid;
  logic              o_ready;
  logic [31:0]       i_inst;
  logic [2:0]        i_fmt;
  logic [TAG_W-1:0]  i_tag;
  logic              i_flush;
  logic              o_valid;
  logic              i_ready;
  logic [XLEN-1:0]   o_imm;
  logic [TAG_W-1:0]  o_tag;
  logic              o_illegal;
`ifdef IMM_STATS_EN
  logic [31:0]       o_stall_cnt;

  modport slave (
    input  i_valid, i_inst, i_fmt, i_tag, i_flush, i_ready,
    output o_ready, o_valid, o_imm, o_tag, o_illegal, o_stall_cnt
  );

  modport master (
    output i_valid, i_inst, i_fmt, i_tag, i_flush, i_ready,
    input  o_ready, o_valid, o_imm, o_tag, o_illegal, o_stall_cnt
  );
`else
  modport slave (
    input  i_valid, i_inst, i_fmt, i_tag, i_flush, i_ready,
    output o_ready, o_valid, o_imm, o_tag, o_illegal
  );

  modport master (
    output i_valid, i_inst, i_fmt, i_tag, i_flush, i_ready,
    input  o_ready, o_valid, o_imm, o_tag, o_illegal
  );
`endif
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: combinational I/S/B/U/J/SHAMT/ZIMM decode
// into a two-entry valid/ready skid buffer carrying {imm, tag, illegal}.
// Optional macro IMM_STATS_EN adds a saturating output-stall counter.
//
// state | meaning
// EMPTY | output register invalid
// ONE   | output register valid, skid register empty
// TWO   | output and skid registers both valid (o_ready low)
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  imm_gen_pipe_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_ZIMM  = 3'd7;

  state_t            state;
  logic              valid_q;
  logic              ready_q;
  logic [XLEN-1:0]   out_imm;
  logic [TAG_W-1:0]  out_tag;
  logic              out_ill;
  logic [XLEN-1:0]   skid_imm;
  logic [TAG_W-1:0]  skid_tag;
  logic              skid_ill;

  logic [XLEN-1:0]   dec_imm;
  logic              dec_ill;
  logic              accept;
  logic              transfer;

  // Opcode bits never contribute to an immediate.
  logic unused_opcode;
  assign unused_opcode = &{1'b0, bus.i_inst[6:0]};

  assign accept   = bus.i_valid && ready_q;
  assign transfer = valid_q && bus.i_ready;

  // Immediate decode; signed casts sign-extend to XLEN, unsigned ones zero-extend.
  always_comb begin
    dec_imm = '0;
    dec_ill = 1'b0;
    case (bus.i_fmt)
      FMT_I: dec_imm = XLEN'($signed(bus.i_inst[31:20]));
      FMT_S: dec_imm = XLEN'($signed({bus.i_inst[31:25], bus.i_inst[11:7]}));
      FMT_B: dec_imm = XLEN'($signed({bus.i_inst[31], bus.i_inst[7],
                                      bus.i_inst[30:25], bus.i_inst[11:8], 1'b0}));
      FMT_U: dec_imm = XLEN'($signed({bus.i_inst[31:12], 12'b0}));
      FMT_J: dec_imm = XLEN'($signed({bus.i_inst[31], bus.i_inst[19:12],
                                      bus.i_inst[20], bus.i_inst[30:21], 1'b0}));
      FMT_SHAMT: begin
        if (XLEN == 64) begin
          dec_imm = XLEN'(bus.i_inst[25:20]);
        end else begin
          // RV32 shifts above 31 are reserved; flag it but still pass shamt[4:0].
          dec_imm = XLEN'(bus.i_inst[24:20]);
          dec_ill = bus.i_inst[25];
        end
      end
      FMT_ZIMM: dec_imm = XLEN'(bus.i_inst[19:15]);
      default:  dec_imm = '0;
    endcase
  end

  // Skid-buffer FSM; reset dominates flush, flush dominates the handshakes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= EMPTY;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      out_imm  <= '0;
      out_tag  <= '0;
      out_ill  <= 1'b0;
      skid_imm <= '0;
      skid_tag <= '0;
      skid_ill <= 1'b0;
    end else if (bus.i_flush) begin
      state   <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_imm <= dec_imm;
            out_tag <= bus.i_tag;
            out_ill <= dec_ill;
            valid_q <= 1'b1;
            state   <= ONE;
          end
        end
        ONE: begin
          if (accept && !transfer) begin
            skid_imm <= dec_imm;
            skid_tag <= bus.i_tag;
            skid_ill <= dec_ill;
            ready_q  <= 1'b0;
            state    <= TWO;
          end else if (accept && transfer) begin
            out_imm <= dec_imm;
            out_tag <= bus.i_tag;
            out_ill <= dec_ill;
          end else if (transfer) begin
            valid_q <= 1'b0;
            state   <= EMPTY;
          end
        end
        TWO: begin
          if (transfer) begin
            out_imm <= skid_imm;
            out_tag <= skid_tag;
            out_ill <= skid_ill;
            ready_q <= 1'b1;
            state   <= ONE;
          end
        end
        default: begin
          state   <= EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.o_valid   = valid_q;
  assign bus.o_ready   = ready_q;
  assign bus.o_imm     = out_imm;
  assign bus.o_tag     = out_tag;
  assign bus.o_illegal = out_ill;

`ifdef IMM_STATS_EN
  logic [31:0] stall_cnt;

  // Saturating count of cycles where a result waits on downstream; only reset clears it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt <= '0;
    end else if (valid_q && !bus.i_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.o_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance,
// scoreboard of expected {imm, tag, illegal} plus per-scenario checks.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) b64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u32 (.i_clk(clk), .i_rst(rst), .bus(b32.slave));
  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u64 (.i_clk(clk), .i_rst(rst), .bus(b64.slave));

  typedef struct packed {
    logic [63:0] imm;
    logic [31:0] tag;
    logic        ill;
  } exp_t;

  int checks = 0;
  int errors = 0;
  exp_t q32[$];
  exp_t q64[$];
  int unsigned stall_exp32 = 0;
  int unsigned stall_exp64 = 0;

  function automatic exp_t model(logic [31:0] inst, logic [2:0] fmt, logic [31:0] tag, int xlen);
    exp_t e;
    logic [63:0] r;
    logic s;
    s = inst[31];
    case (fmt)
      3'd1: r = {{52{s}}, inst[31:20]};
      3'd2: r = {{52{s}}, inst[31:25], inst[11:7]};
      3'd3: r = {{51{s}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      3'd4: r = {{32{s}}, inst[31:12], 12'h000};
      3'd5: r = {{43{s}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      3'd6: r = (xlen == 64) ? {58'd0, inst[25:20]} : {59'd0, inst[24:20]};
      3'd7: r = {59'd0, inst[19:15]};
      default: r = 64'd0;
    endcase
    if (xlen == 32) r[63:32] = 32'd0;
    e.imm = r;
    e.tag = tag;
    e.ill = (fmt == 3'd6) && (xlen == 32) && inst[25];
    return e;
  endfunction

  // One clock: scoreboard both instances at the negedge, return 1 unit after posedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rst) begin
      q32.delete();
      q64.delete();
      stall_exp32 = 0;
      stall_exp64 = 0;
    end else begin
      if (b32.o_valid && !b32.i_ready && stall_exp32 != 32'hFFFF_FFFF) stall_exp32++;
      if (b64.o_valid && !b64.i_ready && stall_exp64 != 32'hFFFF_FFFF) stall_exp64++;
      if (b32.o_valid && b32.i_ready) begin
        checks++;
        if (q32.size() == 0) begin
          errors++;
          $display("FAIL sb32_extra: got tag=%h with nothing expected", b32.o_tag);
        end else begin
          e = q32.pop_front();
          if ({32'd0, b32.o_imm} !== e.imm || b32.o_tag !== e.tag || b32.o_illegal !== e.ill) begin
            errors++;
            $display("FAIL sb32_data: got imm=%h tag=%h ill=%b, expected imm=%h tag=%h ill=%b",
                     b32.o_imm, b32.o_tag, b32.o_illegal, e.imm[31:0], e.tag, e.ill);
          end
        end
      end
      if (b64.o_valid && b64.i_ready) begin
        checks++;
        if (q64.size() == 0) begin
          errors++;
          $display("FAIL sb64_extra: got tag=%h with nothing expected", b64.o_tag);
        end else begin
          e = q64.pop_front();
          if (b64.o_imm !== e.imm || b64.o_tag !== e.tag || b64.o_illegal !== e.ill) begin
            errors++;
            $display("FAIL sb64_data: got imm=%h tag=%h ill=%b, expected imm=%h tag=%h ill=%b",
                     b64.o_imm, b64.o_tag, b64.o_illegal, e.imm, e.tag, e.ill);
          end
        end
      end
      if (b32.i_flush) q32.delete();
      else if (b32.i_valid && b32.o_ready) q32.push_back(model(b32.i_inst, b32.i_fmt, b32.i_tag, 32));
      if (b64.i_flush) q64.delete();
      else if (b64.i_valid && b64.o_ready) q64.push_back(model(b64.i_inst, b64.i_fmt, b64.i_tag, 64));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    b32.i_valid = 1'b0; b32.i_inst = '0; b32.i_fmt = '0; b32.i_tag = '0;
    b32.i_flush = 1'b0; b32.i_ready = 1'b1;
    b64.i_valid = 1'b0; b64.i_inst = '0; b64.i_fmt = '0; b64.i_tag = '0;
    b64.i_flush = 1'b0; b64.i_ready = 1'b1;
  endtask

  task automatic check_reset_values(string name);
    checks++;
    if (b32.o_valid !== 1'b0 || b32.o_ready !== 1'b1 || b32.o_imm !== 32'd0 ||
        b32.o_tag !== 32'd0 || b32.o_illegal !== 1'b0) begin
      errors++;
      $display("FAIL %s_32: got valid=%b ready=%b imm=%h tag=%h ill=%b, expected 0 1 0 0 0",
               name, b32.o_valid, b32.o_ready, b32.o_imm, b32.o_tag, b32.o_illegal);
    end
    checks++;
    if (b64.o_valid !== 1'b0 || b64.o_ready !== 1'b1 || b64.o_imm !== 64'd0 ||
        b64.o_tag !== 32'd0 || b64.o_illegal !== 1'b0) begin
      errors++;
      $display("FAIL %s_64: got valid=%b ready=%b imm=%h tag=%h ill=%b, expected 0 1 0 0 0",
               name, b64.o_valid, b64.o_ready, b64.o_imm, b64.o_tag, b64.o_illegal);
    end
`ifdef IMM_STATS_EN
    checks++;
    if (b32.o_stall_cnt !== 32'd0 || b64.o_stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL %s_stall: got %0d/%0d, expected 0/0", name, b32.o_stall_cnt, b64.o_stall_cnt);
    end
`endif
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1'b1;
    b32.i_valid = 1'b1; b32.i_fmt = 3'd1; b32.i_inst = 32'hFFF0_0093; b32.i_tag = 32'hDEAD;
    b32.i_flush = 1'b1; b32.i_ready = 1'b0;
    tick();
    tick();
    check_reset_values("reset");
    rst = 1'b0;
    idle_all();
    tick();
    checks++;
    if (b32.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_input_ignored: got o_valid=%b, expected 0", b32.o_valid);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] insts [8] = '{32'hFFF0_0093, 32'hFE00_0EE3, 32'h0080_006F, 32'h0230_1013,
                               32'h8000_0F80, 32'h800F_8073, 32'hFFFF_FFFF, 32'h0000_0000};
    logic [2:0]  fmts  [8] = '{3'd1, 3'd3, 3'd5, 3'd6, 3'd2, 3'd7, 3'd0, 3'd0};
    logic [31:0] imms  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0000_0003,
                               32'hFFFF_F81F, 32'h0000_001F, 32'h0000_0000, 32'h0000_0000};
    logic        ills  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] insts64 [2] = '{32'h8000_02B7, 32'h03F0_1013};
    logic [2:0]  fmts64  [2] = '{3'd4, 3'd6};
    logic [63:0] imms64  [2] = '{64'hFFFF_FFFF_8000_0000, 64'd63};
    idle_all();
    for (int i = 0; i < 7; i++) begin
      b32.i_valid = 1'b1; b32.i_inst = insts[i]; b32.i_fmt = fmts[i]; b32.i_tag = 32'h1000 + i;
      tick();
      b32.i_valid = 1'b0;
      checks++;
      if (b32.o_valid !== 1'b1 || b32.o_imm !== imms[i] || b32.o_tag !== (32'h1000 + i) ||
          b32.o_illegal !== ills[i]) begin
        errors++;
        $display("FAIL vec32_%0d: got valid=%b imm=%h tag=%h ill=%b, expected 1 %h %h %b",
                 i, b32.o_valid, b32.o_imm, b32.o_tag, b32.o_illegal, imms[i], 32'h1000 + i, ills[i]);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      b64.i_valid = 1'b1; b64.i_inst = insts64[i]; b64.i_fmt = fmts64[i]; b64.i_tag = 32'h2000 + i;
      tick();
      b64.i_valid = 1'b0;
      checks++;
      if (b64.o_valid !== 1'b1 || b64.o_imm !== imms64[i] || b64.o_tag !== (32'h2000 + i) ||
          b64.o_illegal !== 1'b0) begin
        errors++;
        $display("FAIL vec64_%0d: got valid=%b imm=%h tag=%h ill=%b, expected 1 %h %h 0",
                 i, b64.o_valid, b64.o_imm, b64.o_tag, b64.o_illegal, imms64[i], 32'h2000 + i);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    idle_all();
    for (int i = 0; i < 8; i++) begin
      b32.i_valid = 1'b1; b32.i_inst = $urandom; b32.i_fmt = 3'($urandom_range(0, 7));
      b32.i_tag = 32'd100 + i;
      tick();
      checks++;
      if (b32.o_valid !== 1'b1 || b32.o_ready !== 1'b1 || b32.o_tag !== (32'd100 + i)) begin
        errors++;
        $display("FAIL b2b_%0d: got valid=%b ready=%b tag=%0d, expected 1 1 %0d",
                 i, b32.o_valid, b32.o_ready, b32.o_tag, 100 + i);
      end
    end
    b32.i_valid = 1'b0;
    tick();
    checks++;
    if (b32.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got o_valid=%b, expected 0", b32.o_valid);
    end
  endtask

  task automatic test_backpressure();
    idle_all();
    b32.i_ready = 1'b0;
    b32.i_valid = 1'b1; b32.i_fmt = 3'd1; b32.i_inst = $urandom; b32.i_tag = 32'd1;
    tick();
    checks++;
    if (b32.o_valid !== 1'b1 || b32.o_ready !== 1'b1 || b32.o_tag !== 32'd1) begin
      errors++;
      $display("FAIL bp_first: got valid=%b ready=%b tag=%0d, expected 1 1 1",
               b32.o_valid, b32.o_ready, b32.o_tag);
    end
    b32.i_inst = $urandom; b32.i_fmt = 3'd5; b32.i_tag = 32'd2;
    tick();
    checks++;
    if (b32.o_ready !== 1'b0 || b32.o_tag !== 32'd1) begin
      errors++;
      $display("FAIL bp_full: got ready=%b tag=%0d, expected 0 1", b32.o_ready, b32.o_tag);
    end
    b32.i_inst = $urandom; b32.i_fmt = 3'd2; b32.i_tag = 32'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (b32.o_ready !== 1'b0 || b32.o_valid !== 1'b1 || b32.o_tag !== 32'd1) begin
        errors++;
        $display("FAIL bp_hold_%0d: got ready=%b valid=%b tag=%0d, expected 0 1 1",
                 i, b32.o_ready, b32.o_valid, b32.o_tag);
      end
    end
`ifdef IMM_STATS_EN
    checks++;
    if (b32.o_stall_cnt !== stall_exp32) begin
      errors++;
      $display("FAIL bp_stall_cnt: got %0d, expected %0d", b32.o_stall_cnt, stall_exp32);
    end
`endif
    b32.i_ready = 1'b1;
    tick();
    checks++;
    if (b32.o_tag !== 32'd2 || b32.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_rel1: got tag=%0d ready=%b, expected 2 1", b32.o_tag, b32.o_ready);
    end
    tick();
    b32.i_valid = 1'b0;
    checks++;
    if (b32.o_tag !== 32'd3 || b32.o_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_rel2: got tag=%0d valid=%b, expected 3 1", b32.o_tag, b32.o_valid);
    end
    tick();
    checks++;
    if (b32.o_valid !== 1'b0 || q32.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: got valid=%b pending=%0d, expected 0 0", b32.o_valid, q32.size());
    end
  endtask

  task automatic test_flush();
    idle_all();
    b32.i_ready = 1'b0;
    b32.i_valid = 1'b1; b32.i_fmt = 3'd4; b32.i_inst = $urandom; b32.i_tag = 32'h11;
    tick();
    b32.i_tag = 32'h12;
    tick();
    checks++;
    if (b32.o_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_setup: got ready=%b, expected 0", b32.o_ready);
    end
    b32.i_flush = 1'b1; b32.i_tag = 32'h13;
    tick();
    checks++;
    if (b32.o_valid !== 1'b0 || b32.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_empty: got valid=%b ready=%b, expected 0 1", b32.o_valid, b32.o_ready);
    end
`ifdef IMM_STATS_EN
    checks++;
    if (b32.o_stall_cnt !== stall_exp32) begin
      errors++;
      $display("FAIL flush_stall_kept: got %0d, expected %0d", b32.o_stall_cnt, stall_exp32);
    end
`endif
    b32.i_flush = 1'b0; b32.i_tag = 32'h55; b32.i_fmt = 3'd7;
    tick();
    b32.i_valid = 1'b0;
    checks++;
    if (b32.o_valid !== 1'b1 || b32.o_tag !== 32'h55) begin
      errors++;
      $display("FAIL flush_refill: got valid=%b tag=%h, expected 1 55", b32.o_valid, b32.o_tag);
    end
    b32.i_ready = 1'b1;
    tick();
    checks++;
    if (b32.o_valid !== 1'b0 || q32.size() != 0) begin
      errors++;
      $display("FAIL flush_drain: got valid=%b pending=%0d, expected 0 0", b32.o_valid, q32.size());
    end
  endtask

  task automatic test_reset_midstream();
    idle_all();
    b32.i_ready = 1'b0; b64.i_ready = 1'b0;
    b32.i_valid = 1'b1; b32.i_fmt = 3'd3; b32.i_inst = $urandom; b32.i_tag = 32'h21;
    b64.i_valid = 1'b1; b64.i_fmt = 3'd4; b64.i_inst = 32'h8000_0000; b64.i_tag = 32'h31;
    tick();
    b32.i_tag = 32'h22; b64.i_tag = 32'h32;
    tick();
    b32.i_tag = 32'h23;
    rst = 1'b1;
    b32.i_flush = 1'b1;
    tick();
    check_reset_values("rst_mid");
    rst = 1'b0;
    idle_all();
    tick();
    checks++;
    if (b32.o_valid !== 1'b0 || b64.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_after: got valid32=%b valid64=%b, expected 0 0", b32.o_valid, b64.o_valid);
    end
  endtask

  task automatic test_random();
    logic            pv32, pr32, pf32, pill32;
    logic [31:0]     pimm32, ptag32;
    logic            pv64, pr64, pf64;
    logic [63:0]     pimm64;
    int              guard;
    idle_all();
    for (int i = 0; i < 400; i++) begin
      b32.i_valid = ($urandom_range(0, 3) != 0);
      b32.i_inst  = $urandom;
      b32.i_fmt   = 3'($urandom_range(0, 7));
      b32.i_tag   = $urandom;
      b32.i_ready = ($urandom_range(0, 2) != 0);
      b32.i_flush = ($urandom_range(0, 40) == 0);
      b64.i_valid = ($urandom_range(0, 3) != 0);
      b64.i_inst  = $urandom;
      b64.i_fmt   = 3'($urandom_range(0, 7));
      b64.i_tag   = $urandom;
      b64.i_ready = ($urandom_range(0, 2) != 0);
      b64.i_flush = ($urandom_range(0, 40) == 0);
      pv32 = b32.o_valid; pr32 = b32.i_ready; pf32 = b32.i_flush;
      pimm32 = b32.o_imm; ptag32 = b32.o_tag; pill32 = b32.o_illegal;
      pv64 = b64.o_valid; pr64 = b64.i_ready; pf64 = b64.i_flush; pimm64 = b64.o_imm;
      tick();
      if (pv32 && !pr32 && !pf32) begin
        checks++;
        if (b32.o_valid !== 1'b1 || b32.o_imm !== pimm32 || b32.o_tag !== ptag32 ||
            b32.o_illegal !== pill32) begin
          errors++;
          $display("FAIL stable32_%0d: got valid=%b imm=%h tag=%h, expected 1 %h %h",
                   i, b32.o_valid, b32.o_imm, b32.o_tag, pimm32, ptag32);
        end
      end
      if (pv64 && !pr64 && !pf64) begin
        checks++;
        if (b64.o_valid !== 1'b1 || b64.o_imm !== pimm64) begin
          errors++;
          $display("FAIL stable64_%0d: got valid=%b imm=%h, expected 1 %h",
                   i, b64.o_valid, b64.o_imm, pimm64);
        end
      end
    end
    idle_all();
    guard = 0;
    while ((b32.o_valid || b64.o_valid) && guard < 10) begin
      tick();
      guard++;
    end
    checks++;
    if (b32.o_valid !== 1'b0 || b64.o_valid !== 1'b0 || q32.size() != 0 || q64.size() != 0) begin
      errors++;
      $display("FAIL random_drain: got valid=%b/%b pending=%0d/%0d, expected 0/0 0/0",
               b32.o_valid, b64.o_valid, q32.size(), q64.size());
    end
`ifdef IMM_STATS_EN
    checks++;
    if (b32.o_stall_cnt !== stall_exp32 || b64.o_stall_cnt !== stall_exp64) begin
      errors++;
      $display("FAIL random_stall: got %0d/%0d, expected %0d/%0d",
               b32.o_stall_cnt, b64.o_stall_cnt, stall_exp32, stall_exp64);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    test_reset();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
